// File: rtl/logs_pwm_demod.sv
// PWM duty-cycle demodulator: counts high samples per 2^K-clock window.
// Define LOGS_PWM_ALIGN_EN to align windows to PWM frame rising edges.
module logs_pwm_demod #(
  parameter int K           = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [K:0]   level_out,
  output logic         level_valid,
  output logic         locked
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [K-1:0]           win_cnt;
  logic [K-1:0]           win_nxt;
  logic [K:0]             acc;
  logic [K:0]             acc_nxt;
  logic [K:0]             level_nxt;
  logic                   valid_nxt;
  logic                   last;

  assign s    = sync_q[SYNC_STAGES-1];
  assign last = (win_cnt == {K{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef LOGS_PWM_ALIGN_EN
  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t state;
  state_t state_nxt;
  logic   s_prev;
  logic   rise;

  assign rise   = s & ~s_prev;
  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= UNLOCKED;
      s_prev <= 1'b0;
    end else begin
      state  <= state_nxt;
      s_prev <= s;
    end
  end
`else
  assign locked = 1'b1;
`endif

  always_comb begin
    win_nxt   = win_cnt + K'(1);
    acc_nxt   = acc + (K+1)'(s);
    level_nxt = level_out;
    valid_nxt = 1'b0;
    if (last) begin
      level_nxt = acc_nxt;
      valid_nxt = 1'b1;
      acc_nxt   = '0;
    end
`ifdef LOGS_PWM_ALIGN_EN
    state_nxt = state;
    unique case (state)
      UNLOCKED: begin
        win_nxt   = '0;
        acc_nxt   = '0;
        level_nxt = level_out;
        valid_nxt = 1'b0;
        if (rise) begin
          win_nxt   = K'(1);
          acc_nxt   = (K+1)'(1);
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // a rise off slot 0 means we drifted: restart the window on it
        if (rise && win_cnt != '0) begin
          win_nxt   = K'(1);
          acc_nxt   = (K+1)'(1);
          level_nxt = level_out;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      acc         <= '0;
      level_out   <= '0;
      level_valid <= 1'b0;
    end else begin
      win_cnt     <= win_nxt;
      acc         <= acc_nxt;
      level_out   <= level_nxt;
      level_valid <= valid_nxt;
    end
  end

endmodule

// File: doc/logs_pwm_demod.md
Name: logs_pwm_demod

Overview:
- Receive-side counterpart of the audio mixer's PWM output.
- Samples a 1-bit PWM audio line and measures its duty cycle over fixed windows of 2^K clocks. Reports the count of high cycles per window as a multi-bit level with a one-cycle valid strobe.
- Used for loopback self-test of the mixer output, and to feed a downstream level meter.

Parameters:
- K, 2, window length is 2^K clocks; must be >= 1.
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- pwm_in  input  1  PWM audio line, possibly asynchronous
- level_out  output  K+1  high-cycle count of the last completed window, range 0..2^K
- level_valid  output  1  one-cycle strobe: level_out updated this cycle
- locked  output  1  window is aligned to the PWM frame

Behaviour:
- Reset (rst high at a clk edge) sets the following to 0:
  - synchronizer chain, edge-detect register s_prev
  - window counter win_cnt (K bits), accumulator acc (K+1 bits)
  - level_out, level_valid
  - locked, if LOGS_PWM_ALIGN_EN is defined; otherwise locked is constant 1.
- Reset takes priority over all other activity. Reset mid-window discards the partial window; no strobe is produced for it.
- Sampling:
  - pwm_in passes through SYNC_STAGES flops; the last stage is the sample s.
  - s_prev holds s delayed by one clock.
  - Input-to-sample latency is SYNC_STAGES clocks.
- Measurement in free-running mode (macro off), every cycle:
  - win_cnt <= win_cnt + 1, wrapping modulo 2^K.
  - If win_cnt != 2^K-1: acc <= acc + s.
  - If win_cnt == 2^K-1 (end of window):
    - level_out <= acc + s.
    - level_valid <= 1.
    - acc <= 0.
- Otherwise level_valid <= 0, so the strobe is exactly one cycle, every 2^K cycles.
- First strobe: the cycle after win_cnt first reaches 2^K-1 following reset.
- Width: acc and level_out are K+1 bits, so an all-high window reports exactly 2^K with no wrap. An all-low window reports 0.
- level_out holds its value between strobes.
- With the mixer as source, level_out equals the mixer's sum (its output rises only at slot 0 and is always low at slot 2^K-1), provided the window is aligned (see Optional Feature).

Optional Feature:
- Macro: LOGS_PWM_ALIGN_EN.
- Defined: a two-state FSM, UNLOCKED and LOCKED, aligns windows to the rising edges of the PWM frame.
  - rise = s & ~s_prev.
  - UNLOCKED (the reset state; locked=0, level_valid held 0):
    - win_cnt and acc are held at 0.
    - On rise: win_cnt <= 1, acc <= 1 (the rising sample counts as slot 0), then go to LOCKED.
  - LOCKED (locked=1): measurement is as in free-running mode.
    - If rise occurs with win_cnt == 0: normal operation.
    - If rise occurs with win_cnt != 0 (misaligned): discard the partial window, set win_cnt <= 1 and acc <= 1, stay LOCKED, no strobe this window.
    - If rise coincides with win_cnt == 2^K-1, the misaligned rule wins: no strobe.
  - An all-low input never locks; level_valid stays 0.
  - A constant-high input locks once, on its single rise, then reports 2^K every window.
- Not defined: no FSM; free-running windows starting at reset; locked tied to 1.

Test Plan (K=2, SYNC_STAGES=2):
- Macro off; reset, then pwm_in held 0 -> level_valid pulses every 4 clocks; level_out=0 each time; locked=1.
- Macro off; pwm_in constant 1 from reset release -> after pipeline fill, every strobe gives level_out=4 (3'b100), no wrap to 0.
- Macro on; repeating pattern 1,1,0,0 started at an arbitrary offset -> locked rises 3 clocks after the first pwm_in rise; every subsequent strobe gives level_out=2.
- Macro on; pattern 1,0,0,0 locked, then a single extra high pulse injected mid-window -> that window produces no strobe; realign; following windows report level_out=1.
- Macro on; pattern 1,1,1,0; assert rst for 1 cycle mid-window -> level_out=0, level_valid=0, locked=0 next cycle; relocks on the next rise; then level_out=3.
- Macro on; pwm_in all zeros for 100 clocks -> locked=0 and level_valid=0 throughout.
